// File: rtl/headlight_pkg.sv
// Shared types for the turn-signal path: conditioner FSM states and the
// one-hot command encoding consumed by the tailLight sequencer.
package headlight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } turn_state_e;

  // Command vector order is {lt, rt, haz}.
  function automatic logic [2:0] state_to_cmd(input turn_state_e st);
    logic [2:0] cmd;
    case (st)
      LEFT:    cmd = 3'b100;
      RIGHT:   cmd = 3'b010;
      HAZARD:  cmd = 3'b001;
      default: cmd = 3'b000;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/turn_cmd_conditioner_chk.sv
// Invariant monitors for the conditioner outputs and its timeout counter.
module turn_cmd_conditioner_chk #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                              clk,
  input logic                              rst_n,
  input logic                              lt,
  input logic                              rt,
  input logic                              haz,
  input logic [$clog2(TIMEOUT_CYCLES)-1:0] tmo
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  a_cmd_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({lt, rt, haz}));

  a_tmo_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    tmo <= TMO_LAST);

  a_tmo_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (!lt && !rt) |-> (tmo == '0));

endmodule

// File: rtl/turn_cmd_conditioner_switch_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer: the output only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Metastability guard for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The run counter restarts whenever the synced level agrees with stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= ~r_stable;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_stable;

endmodule

// File: rtl/turn_cmd_conditioner.sv
// Conditions raw stalk/hazard switches into clean, mutually exclusive,
// registered lt/rt/haz commands with steering cancel and turn timeout.
module turn_cmd_conditioner
  import headlight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic lt_raw,
  input  logic rt_raw,
  input  logic haz_raw,
  input  logic cancel,
  output logic lt,
  output logic rt,
  output logic haz
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic w_lt_db;
  logic w_rt_db;
  logic w_haz_db;
  logic w_lt_rise;
  logic w_rt_rise;
  logic w_haz_cond;
  logic w_tmo_done;

  turn_state_e   r_state;
  logic [TW-1:0] r_tmo;
  logic          r_lt_prev;
  logic          r_rt_prev;
  logic          r_lt;
  logic          r_rt;
  logic          r_haz;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lt_db (
    .clk     (clk),
    .rst_n   (rst),
    .i_raw   (lt_raw),
    .o_level (w_lt_db)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rt_db (
    .clk     (clk),
    .rst_n   (rst),
    .i_raw   (rt_raw),
    .o_level (w_rt_db)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_haz_db (
    .clk     (clk),
    .rst_n   (rst),
    .i_raw   (haz_raw),
    .o_level (w_haz_db)
  );

  assign w_lt_rise  = w_lt_db & ~r_lt_prev;
  assign w_rt_rise  = w_rt_db & ~r_rt_prev;
  assign w_haz_cond = w_haz_db | (w_lt_db & w_rt_db);
  assign w_tmo_done = (r_tmo == TMO_LAST);

  // Turn arbitration: hazard, then hazard release, then new stalk edges,
  // then cancel/timeout. Outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tmo     <= '0;
      r_lt_prev <= 1'b0;
      r_rt_prev <= 1'b0;
      {r_lt, r_rt, r_haz} <= 3'b000;
    end else begin
      r_lt_prev <= w_lt_db;
      r_rt_prev <= w_rt_db;
      if (w_haz_cond) begin
        r_state <= HAZARD;
        r_tmo   <= '0;
        {r_lt, r_rt, r_haz} <= state_to_cmd(HAZARD);
      end else begin
        case (r_state)
          IDLE, LEFT, RIGHT: begin
            if (w_lt_rise) begin
              r_state <= LEFT;
              r_tmo   <= '0;
              {r_lt, r_rt, r_haz} <= state_to_cmd(LEFT);
            end else if (w_rt_rise) begin
              r_state <= RIGHT;
              r_tmo   <= '0;
              {r_lt, r_rt, r_haz} <= state_to_cmd(RIGHT);
            end else if ((r_state == IDLE) || cancel || w_tmo_done) begin
              r_state <= IDLE;
              r_tmo   <= '0;
              {r_lt, r_rt, r_haz} <= state_to_cmd(IDLE);
            end else begin
              r_state <= r_state;
              r_tmo   <= r_tmo + TW'(1);
              {r_lt, r_rt, r_haz} <= state_to_cmd(r_state);
            end
          end
          default: begin
            // Leaving hazard never resumes a turn; a fresh stalk edge is needed.
            r_state <= IDLE;
            r_tmo   <= '0;
            {r_lt, r_rt, r_haz} <= state_to_cmd(IDLE);
          end
        endcase
      end
    end
  end

  assign lt  = r_lt;
  assign rt  = r_rt;
  assign haz = r_haz;

  turn_cmd_conditioner_chk #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_chk (
    .clk   (clk),
    .rst_n (rst),
    .lt    (r_lt),
    .rt    (r_rt),
    .haz   (r_haz),
    .tmo   (r_tmo)
  );

endmodule

// File: tb/tb_turn_cmd_conditioner.sv
// Randomized and directed bench for turn_cmd_conditioner with a cycle-level
// behavioural reference model compared on every clock.
module tb_turn_cmd_conditioner;

  localparam int D = 4;
  localparam int T = 16;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic lt_raw  = 1'b0;
  logic rt_raw  = 1'b0;
  logic haz_raw = 1'b0;
  logic cancel  = 1'b0;
  logic lt;
  logic rt;
  logic haz;

  int vectors     = 0;
  int miscompares = 0;

  turn_cmd_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lt_raw  (lt_raw),
    .rt_raw  (rt_raw),
    .haz_raw (haz_raw),
    .cancel  (cancel),
    .lt      (lt),
    .rt      (rt),
    .haz     (haz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {lt,rt,haz}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[i][j] = raw value of input i sampled j edges ago (index 0 = lt, 1 = rt, 2 = haz)
  logic [15:0] m_hist [3];
  logic [2:0]  m_db;
  logic [2:0]  m_prev;
  int          m_mode;     // 0 idle, 1 left, 2 right, 3 hazard
  int          m_cyc;
  int          m_entered;

  function automatic logic [2:0] model_cmd();
    case (m_mode)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0] raw;
    logic       all_diff;
    if (!rst) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_db = '0; m_prev = '0; m_mode = 0; m_cyc = 0; m_entered = 0;
      return;
    end
    m_cyc++;
    raw = {haz_raw, rt_raw, lt_raw};
    if (m_db[2] || (m_db[0] && m_db[1])) m_mode = 3;
    else if (m_mode == 3) m_mode = 0;
    else if (m_db[0] && !m_prev[0]) begin m_mode = 1; m_entered = m_cyc; end
    else if (m_db[1] && !m_prev[1]) begin m_mode = 2; m_entered = m_cyc; end
    else if (m_mode == 1 || m_mode == 2) begin
      // a turn is held for at most T clocks after the edge that entered it
      if (cancel || (m_cyc - m_entered) == T) m_mode = 0;
    end
    m_prev = m_db;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][14:0], raw[i]};
      // the debouncer sees the raw value two edges late; flip after D opposite samples
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (m_hist[i][j] == m_db[i]) all_diff = 1'b0;
      if (all_diff) m_db[i] = ~m_db[i];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cycle", {lt, rt, haz}, model_cmd());
    end
  end

  // ---------------- directed helpers ----------------
  // n = index of the edge (0 = first edge after call) after which the output hits val
  task automatic wait_out(input int which, input logic val, input int budget, output int n);
    logic cur;
    n = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      cur = (which == 0) ? lt : (which == 1) ? rt : haz;
      if (cur == val) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic count_active(input int cycles, output int highs);
    highs = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (lt || rt || haz) highs++;
    end
  endtask

  task automatic pulse_cancel();
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int         n;
  int         highs;
  int         dur;
  int         hold [3];
  logic [2:0] rv;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {lt, rt, haz}, 3'b000);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // left turn then cancel
    lt_raw = 1'b1;
    wait_out(0, 1'b1, 20, n);
    check_n("lt_latency", n, 6);
    check("lt_only", {lt, rt, haz}, 3'b100);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_next_cycle", {lt, rt, haz}, 3'b000);
    @(negedge clk); cancel = 1'b0; lt_raw = 1'b0;
    repeat (10) @(negedge clk);

    // bounce rejection: 3-high/3-low pulses
    highs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); lt_raw = ((c / 3) % 2) == 0;
      @(posedge clk); #1;
      if (lt) highs++;
    end
    check_n("bounce_ignored", highs, 0);
    @(negedge clk); lt_raw = 1'b1;
    wait_out(0, 1'b1, 20, n);
    check_n("lt_after_bounce", n, 6);
    pulse_cancel();
    lt_raw = 1'b0;
    repeat (10) @(negedge clk);

    // timeout
    rt_raw = 1'b1;
    wait_out(1, 1'b1, 20, n);
    check_n("rt_latency", n, 6);
    dur = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (!rt) break;
      dur++;
    end
    check_n("rt_timeout_len", dur, T);
    count_active(20, highs);
    check_n("no_reentry_held", highs, 0);
    @(negedge clk); rt_raw = 1'b0;
    repeat (10) @(negedge clk);

    // left, override right, hazard, release hazard with rt held
    lt_raw = 1'b1;
    wait_out(0, 1'b1, 20, n);
    check_n("lt_latency2", n, 6);
    @(negedge clk); lt_raw = 1'b0;
    repeat (4) @(negedge clk);
    rt_raw = 1'b1;
    wait_out(1, 1'b1, 20, n);
    check_n("override_latency", n, 6);
    check("override_rt", {lt, rt, haz}, 3'b010);
    @(negedge clk); haz_raw = 1'b1;
    wait_out(2, 1'b1, 20, n);
    check_n("haz_latency", n, 6);
    check("haz_only", {lt, rt, haz}, 3'b001);
    @(negedge clk); haz_raw = 1'b0;
    wait_out(2, 1'b0, 20, n);
    check_n("haz_release_latency", n, 6);
    check("haz_release_idle", {lt, rt, haz}, 3'b000);
    count_active(10, highs);
    check_n("held_rt_no_turn", highs, 0);
    @(negedge clk); rt_raw = 1'b0;
    repeat (10) @(negedge clk);

    // both stalks together
    lt_raw = 1'b1; rt_raw = 1'b1;
    wait_out(2, 1'b1, 20, n);
    check_n("both_haz_latency", n, 6);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    check("haz_ignores_cancel", {lt, rt, haz}, 3'b001);
    @(negedge clk); cancel = 1'b0; lt_raw = 1'b0; rt_raw = 1'b0;
    wait_out(2, 1'b0, 20, n);
    check_n("both_release", n, 6);
    repeat (10) @(negedge clk);

    // mid-turn reset
    lt_raw = 1'b1;
    wait_out(0, 1'b1, 20, n);
    @(negedge clk); rst = 1'b0;
    #1;
    check("async_reset", {lt, rt, haz}, 3'b000);
    @(negedge clk); rst = 1'b1;
    wait_out(0, 1'b1, 20, n);
    check_n("reentry_after_reset", n, 6);
    pulse_cancel();
    lt_raw = 1'b0;
    repeat (10) @(negedge clk);

    // randomized phase
    for (int i = 0; i < 3; i++) hold[i] = 0;
    rv = 3'b000;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          if (i == 2) rv[i] = ($urandom_range(0, 3) == 0);
          else        rv[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 40));
        end else begin
          hold[i]--;
        end
      end
      lt_raw  = rv[0];
      rt_raw  = rv[1];
      haz_raw = rv[2];
      cancel  = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 799) != 0);
    end
    @(negedge clk);
    rst = 1'b1; cancel = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
